// File: rtl/half_adder_2_bits_checker.sv
// Scores a stream of adder observations against a+b; counters update on the accepting edge (latency 1).
// Back-pressure: in_ready is high only in RUN, so observations are refused outside a run.
module half_adder_2_bits_checker #(
   parameter int WIDTH       = 2,
   parameter int NUM_VECTORS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      vec_count,
   output logic [15:0]      err_count,
   output logic [WIDTH-1:0] first_err_a,
   output logic [WIDTH-1:0] first_err_b,
   output logic             first_err_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0]      vec;
      logic [15:0]      err;
      logic             fv;
      logic [WIDTH-1:0] fa;
      logic [WIDTH-1:0] fb;
   } res_t;

   localparam logic [15:0] LAST_VEC_IDX = 16'(NUM_VECTORS - 1);

   state_t state_q, state_d;
   res_t   res_q, res_d;

   logic             accept;
   logic [WIDTH:0]   expected;
   logic             mismatch;

   assign accept   = in_valid && (state_q == RUN);
   assign expected = {1'b0, a} + {1'b0, b};
   assign mismatch = ({cout, sum} != expected);

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               res_d   = '0;
            end
         end
         RUN: begin
            if (accept) begin
               res_d.vec = res_q.vec + 16'd1;
               if (mismatch) begin
                  // err_count saturates rather than wrapping
                  if (res_q.err != 16'hFFFF) begin
                     res_d.err = res_q.err + 16'd1;
                  end
                  if (!res_q.fv) begin
                     res_d.fv = 1'b1;
                     res_d.fa = a;
                     res_d.fb = b;
                  end
               end
               if (res_q.vec == LAST_VEC_IDX) begin
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            res_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
      end
   end

   assign in_ready        = (state_q == RUN);
   assign busy            = (state_q == RUN);
   assign done            = (state_q == DONE);
   assign pass            = (state_q == DONE) && (res_q.err == 16'd0);
   assign vec_count       = res_q.vec;
   assign err_count       = res_q.err;
   assign first_err_a     = res_q.fa;
   assign first_err_b     = res_q.fb;
   assign first_err_valid = res_q.fv;

endmodule

// File: tb/tb_half_adder_2_bits_checker.sv
// Scoreboard bench for half_adder_2_bits_checker: per-vector expected counters are queued and compared on acceptance.
module tb_half_adder_2_bits_checker;
   localparam int W = 2;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0, b = '0, sum = '0;
   logic         cout = 1'b0;
   logic         in_ready, busy, done, pass, first_err_valid;
   logic [15:0]  vec_count, err_count;
   logic [W-1:0] first_err_a, first_err_b;

   half_adder_2_bits_checker #(.WIDTH(W), .NUM_VECTORS(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .sum(sum), .cout(cout),
      .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
      .vec_count(vec_count), .err_count(err_count),
      .first_err_a(first_err_a), .first_err_b(first_err_b),
      .first_err_valid(first_err_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] vec;
      logic [15:0] err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int       m_vec, m_err;
   logic [1:0] m_fa, m_fb;
   bit       m_fv, m_run, m_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_vec = 0; m_err = 0; m_fa = '0; m_fb = '0;
      m_fv = 0; m_run = 0; m_done = 0;
      sb_q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_vec"}, vec_count, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_fev"}, first_err_valid, 0);
      chk({tag, "_fea"}, first_err_a, 0);
      chk({tag, "_feb"}, first_err_b, 0);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_busy"}, busy, m_run);
      chk({tag, "_in_ready"}, in_ready, m_run);
      chk({tag, "_done"}, done, m_done);
      chk({tag, "_pass"}, pass, m_done && (m_err == 0));
      chk({tag, "_vec"}, vec_count, m_vec);
      chk({tag, "_err"}, err_count, m_err);
      chk({tag, "_fev"}, first_err_valid, m_fv);
      chk({tag, "_fea"}, first_err_a, m_fa);
      chk({tag, "_feb"}, first_err_b, m_fb);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!m_run) begin
         m_run = 1; m_done = 0; m_vec = 0; m_err = 0;
         m_fv = 0; m_fa = '0; m_fb = '0;
      end
      chk_state("start");
   endtask

   // One cycle of stimulus; accepted observations go through the scoreboard queue.
   task automatic send(input logic [1:0] va, input logic [1:0] vb, input logic [2:0] res,
                       input bit vld, input bit st);
      exp_t     e;
      bit       acc;
      logic [2:0] ex;
      @(negedge clk);
      a = va; b = vb; {cout, sum} = res; in_valid = vld; start = st;
      ex  = {1'b0, va} + {1'b0, vb};
      acc = vld && m_run;
      if (acc) begin
         m_vec++;
         if (res != ex) begin
            if (m_err < 65535) m_err++;
            if (!m_fv) begin
               m_fv = 1; m_fa = va; m_fb = vb;
            end
         end
         if (m_vec == N) begin
            m_run = 0; m_done = 1;
         end
         e.vec = 16'(m_vec);
         e.err = 16'(m_err);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start = 1'b0;
      if (acc) begin
         e = sb_q.pop_front();
         chk("acc_vec", vec_count, e.vec);
         chk("acc_err", err_count, e.err);
         chk("acc_in_ready", in_ready, m_run);
      end else begin
         chk("stall_vec", vec_count, m_vec);
      end
   endtask

   // fault: 0 none, 1 single at (2,3), 2 double at (1,1) and (3,3); gaps inserts idle cycles.
   task automatic run_vectors(input int fault, input bit gaps, input int limit);
      logic [3:0] idx;
      logic [1:0] va, vb;
      logic [2:0] res;
      for (int i = 0; i < limit; i++) begin
         idx = 4'(i);
         va  = idx[3:2];
         vb  = idx[1:0];
         res = {1'b0, va} + {1'b0, vb};
         if (fault == 1 && va == 2'd2 && vb == 2'd3) res = 3'b100;
         if (fault == 2 && va == 2'd1 && vb == 2'd1) res = 3'b000;
         if (fault == 2 && va == 2'd3 && vb == 2'd3) res = 3'b010;
         send(va, vb, res, 1'b1, 1'b0);
         if (gaps && i < limit - 1) send(~va, vb, 3'b111, 1'b0, (i == 4));
      end
   endtask

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #2 chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) send(2'd1, 2'd2, 3'b011, 1'b1, 1'b0);
      chk_state("idle_pulses");

      do_start();
      run_vectors(0, 1'b0, N);
      chk_state("sweep");
      chk("sweep_pass", pass, 1);
      chk("sweep_vec16", vec_count, 16);

      do_start();
      run_vectors(1, 1'b0, N);
      chk_state("single");
      chk("single_err1", err_count, 1);
      chk("single_fa", first_err_a, 2);
      chk("single_fb", first_err_b, 3);

      do_start();
      run_vectors(2, 1'b0, N);
      chk_state("multi");
      chk("multi_err2", err_count, 2);
      chk("multi_fa", first_err_a, 1);
      chk("multi_fb", first_err_b, 1);

      do_start();
      chk("restart_err_clear", err_count, 0);
      run_vectors(0, 1'b0, N);
      chk_state("restart");
      chk("restart_pass", pass, 1);

      do_start();
      run_vectors(0, 1'b1, N);
      chk_state("gaps");
      chk("gaps_vec16", vec_count, 16);
      for (int i = 0; i < 2; i++) send(2'd0, 2'd0, 3'b111, 1'b1, 1'b0);
      chk_state("done_pulses");

      do_start();
      run_vectors(1, 1'b0, 5);
      chk("mid_vec5", vec_count, 5);
      @(negedge clk);
      rst_n = 1'b0;
      #2 chk_all_zero("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_state("post_reset_idle");
      do_start();
      run_vectors(0, 1'b0, N);
      chk_state("after_reset");
      chk("after_reset_pass", pass, 1);

      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/half_adder_2_bits_checker.md
HALF_ADDER_2_BITS_CHECKER -- requirements
Module: half_adder_2_bits_checker

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the operand width of a, b and sum.
REQ-002 Parameter NUM_VECTORS, default 16, SHALL set the number of accepted vectors that completes a run; legal range 1..65535.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit, SHALL request a new checking run.
REQ-006 Port in_valid, input, 1 bit, SHALL indicate that a, b, sum and cout carry one DUT observation.
REQ-007 Port a, input, WIDTH bits, SHALL carry the DUT operand a.
REQ-008 Port b, input, WIDTH bits, SHALL carry the DUT operand b.
REQ-009 Port sum, input, WIDTH bits, SHALL carry the DUT sum output.
REQ-010 Port cout, input, 1 bit, SHALL carry the DUT carry output.
REQ-011 Port in_ready, output, 1 bit, SHALL indicate that the checker accepts an observation this cycle.
REQ-012 Port busy, output, 1 bit, SHALL be high while a run is in progress.
REQ-013 Port done, output, 1 bit, SHALL be high once a run has completed.
REQ-014 Port pass, output, 1 bit, SHALL be high when done=1 and no mismatch was recorded.
REQ-015 Port vec_count, output, 16 bits, SHALL count accepted observations in the current run.
REQ-016 Port err_count, output, 16 bits, SHALL count mismatching observations in the current run.
REQ-017 Ports first_err_a and first_err_b, outputs, WIDTH bits each, SHALL hold the operands of the first mismatch; first_err_valid, output, 1 bit, SHALL be high once they are loaded.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 In IDLE, in_ready, busy and done SHALL be 0, and in_valid SHALL be ignored.
REQ-020 From IDLE or DONE, start=1 SHALL, on the next edge, enter RUN and clear vec_count, err_count, first_err_* and pass.
REQ-021 In RUN, in_ready=1, busy=1 and done=0; start SHALL be ignored.
REQ-022 An observation SHALL be accepted only when in_valid and in_ready are both 1 at a rising edge.
REQ-023 The expected result SHALL be the (WIDTH+1)-bit zero-extended sum a+b; a mismatch exists when {cout,sum} differs from it.
REQ-024 vec_count, err_count and first_err_* SHALL reflect an accepted observation on the edge that accepts it (latency 1 cycle).
REQ-025 err_count SHALL saturate at 16'hFFFF; vec_count cannot exceed NUM_VECTORS.
REQ-026 first_err_* SHALL load only on the first mismatch of a run and hold thereafter.
REQ-027 The edge that accepts the NUM_VECTORS-th observation SHALL move the FSM to DONE; in_ready SHALL be 0 from the following cycle.
REQ-028 In DONE, done=1, busy=0, and pass=(err_count==0); all results SHALL hold until the next start or reset.
REQ-029 Gaps in in_valid during RUN SHALL stall the run without any effect.

Reset
REQ-030 While rst_n=0, the FSM SHALL be in IDLE and all outputs SHALL be 0, regardless of clk.
REQ-031 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Verification
REQ-032 The bench SHALL cover a correct sweep: start, then all 16 (a,b) pairs with correct {cout,sum} -> done=1, pass=1, vec_count=16, err_count=0.
REQ-033 The bench SHALL cover a single fault: a=2, b=3 driven with sum=0, cout=1 (expected sum=1, cout=1), all other vectors correct -> err_count=1, pass=0, first_err_a=2, first_err_b=3, first_err_valid=1.
REQ-034 The bench SHALL cover multiple faults, first at a=1, b=1 and second at a=3, b=3 -> err_count=2, first_err_a=1, first_err_b=1.
REQ-035 The bench SHALL cover in_valid toggled 1,0,1,0 across 16 vectors plus in_valid pulses in IDLE -> vec_count=16 at done, and IDLE pulses are not counted.
REQ-036 The bench SHALL cover rst_n low after 5 accepted vectors -> all outputs 0 immediately, and a subsequent start plus 16 correct vectors -> pass=1.
REQ-037 The bench SHALL cover start in DONE after a failing run -> counters cleared, then 16 correct vectors -> pass=1, err_count=0.
